// File: rtl/exec_monitor_pkg.sv
// Shared types and constants for the CPU execution monitor.
package exec_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted,
    StTimeout
  } state_e;

  localparam logic [1:0] CPU_STATE_FETCH = 2'd0;
  localparam int unsigned CYCLE_WIDTH = 32;

endpackage

// File: rtl/exec_monitor_trace_fifo.sv
// First-word-fall-through write-trace FIFO with a sticky drop flag.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             overflow_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata    = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: rtl/exec_monitor.sv
// Watches a CPU for halt (PC stuck in fetch) or run timeout and traces memory writes.
module exec_monitor
  import exec_monitor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned HALT_CYCLES    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned TRACE_DEPTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [1:0]             cpu_state,
  input  logic                   mem_write,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_write_data,
  input  logic                   trace_rd_en,
  output logic                   trace_valid,
  output logic [ADDR_WIDTH-1:0]  trace_addr,
  output logic [DATA_WIDTH-1:0]  trace_data,
  output logic                   trace_overflow,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   running,
  output logic                   halted,
  output logic                   timed_out
);

  localparam int unsigned StallW = $clog2(HALT_CYCLES + 1);
  localparam logic [StallW-1:0] HaltCount = StallW'(HALT_CYCLES);
  localparam logic [CYCLE_WIDTH-1:0] TimeoutCount = CYCLE_WIDTH'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [CYCLE_WIDTH-1:0]  cycle_q, cycle_d;
  logic [StallW-1:0]       stall_q, stall_d;
  logic [ADDR_WIDTH-1:0]   prev_pc_q, prev_pc_d;
  logic                    fifo_clear;
  logic                    fifo_empty;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rdata;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    stall_d    = stall_q;
    prev_pc_d  = prev_pc_q;
    fifo_clear = 1'b0;
    unique case (state_q)
      StRun: begin
        cycle_d   = cycle_q + 32'd1;
        prev_pc_d = pc;
        stall_d   = (cpu_state == CPU_STATE_FETCH && pc == prev_pc_q) ? stall_q + 1'b1 : '0;
        // Halt is checked first so it wins a tie with timeout.
        if (stall_d == HaltCount)        state_d = StHalted;
        else if (cycle_d == TimeoutCount) state_d = StTimeout;
      end
      default: begin
        if (start) begin
          state_d    = StRun;
          cycle_d    = '0;
          stall_d    = '0;
          prev_pc_d  = '1;
          fifo_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      stall_q   <= '0;
      prev_pc_q <= '1;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      prev_pc_q <= prev_pc_d;
    end
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH)
  ) u_trace_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (state_q == StRun && mem_write),
    .pop      (trace_rd_en),
    .wdata    ({mem_addr, mem_write_data}),
    .rdata    (fifo_rdata),
    .empty    (fifo_empty),
    .overflow (trace_overflow)
  );

  assign trace_valid = !fifo_empty;
  assign trace_addr  = fifo_rdata[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign trace_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign cycle_count = cycle_q;
  assign running     = (state_q == StRun);
  assign halted      = (state_q == StHalted);
  assign timed_out   = (state_q == StTimeout);

endmodule
